cog_cap: RTL and testbench

COG_CAP -- requirements
Module: cog_cap

---
 rtl/cog_cap.sv | 138 +++++++++++++
 tb/tb_cog_cap.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cog_cap.sv
// cog_cap: pin edge capture unit.
// Queues timestamp or delta values of selected pin edges in a FIFO.
module cog_cap #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] TICK_INIT = 32'h0
) (
  input  logic        clk_cog,
  input  logic        ena,
  input  logic        setcap,
  input  logic [31:0] data,
  input  logic [31:0] pin_in,
  input  logic        rdcap,
  output logic [31:0] capval,
  output logic        caplvl,
  output logic        capvld,
  output logic [4:0]  capcnt,
  output logic        ovf
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [4:0] FULL = 5'(DEPTH);

  logic [7:0]    r_cfg;
  logic [1:0]    r_dly;
  logic [31:0]   r_tick;
  logic [31:0]   r_last;
  logic          r_armed;
  logic          r_ovf;
  logic [32:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [4:0]    r_cnt;

  logic        w_pin;
  logic        w_delta;
  logic        w_qual;
  logic        w_push;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;
  logic        w_drop;
  logic        w_lvl;
  logic [31:0] w_val;
  logic        w_unused;

  assign w_unused = ^data[31:8];

  assign w_pin   = pin_in[r_cfg[4:0]];
  assign w_delta = r_cfg[7];
  assign w_lvl   = r_dly[0];

  // setcap swallows any edge in its cycle
  assign w_qual  = ~setcap &
                   (((r_dly == 2'b01) & r_cfg[5]) |
                    ((r_dly == 2'b10) & r_cfg[6]));

  // in delta mode the first edge only arms
  assign w_push  = w_qual & (~w_delta | r_armed);
  assign w_empty = (r_cnt == 5'd0);
  assign w_full  = (r_cnt == FULL);
  assign w_pop   = rdcap & ~w_empty & ~setcap;
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_val   = w_delta ? (r_tick - r_last)
                           : r_tick;

  assign capval = w_empty ? 32'h0
                          : r_mem[r_rptr][31:0];
  assign caplvl = ~w_empty & r_mem[r_rptr][32];
  assign capvld = ~w_empty;
  assign capcnt = r_cnt;
  assign ovf    = r_ovf;

  // pin synchronizer, runs through setcap
  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      r_dly <= 2'b00;
    end else begin
      r_dly <= {r_dly[0], w_pin};
    end
  end

  // config, tick counter, delta tracking, overflow
  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      r_cfg   <= 8'h0;
      r_tick  <= TICK_INIT;
      r_last  <= 32'h0;
      r_armed <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (setcap) begin
      r_cfg   <= data[7:0];
      r_tick  <= TICK_INIT;
      r_armed <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_tick <= r_tick + 32'd1;
      if (w_qual) begin
        r_last  <= r_tick;
        r_armed <= 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // circular FIFO storage and occupancy
  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 33'h0;
      end
    end else if (setcap) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= 5'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= {w_lvl, w_val};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 5'd1;
        2'b01:   r_cnt <= r_cnt - 5'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cog_cap.sv
// tb_cog_cap: directed bench for cog_cap.
// Two instances: default tick start and one near wraparound.
module tb_cog_cap;

  localparam int          DEPTH = 4;
  localparam logic [31:0] WBASE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        ena = 1'b0;
  logic        setcap = 1'b0;
  logic [31:0] data = 32'h0;
  logic [31:0] pin_in = 32'h0;
  logic        rdcap = 1'b0;

  logic [31:0] o_val [2];
  logic        o_lvl [2];
  logic        o_vld [2];
  logic [4:0]  o_cnt [2];
  logic        o_ovf [2];

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cog_cap #(.DEPTH(DEPTH)) dut (
    .clk_cog(clk), .ena(ena), .setcap(setcap),
    .data(data), .pin_in(pin_in), .rdcap(rdcap),
    .capval(o_val[0]), .caplvl(o_lvl[0]),
    .capvld(o_vld[0]), .capcnt(o_cnt[0]),
    .ovf(o_ovf[0])
  );

  cog_cap #(.DEPTH(DEPTH), .TICK_INIT(WBASE)) dut_w (
    .clk_cog(clk), .ena(ena), .setcap(setcap),
    .data(data), .pin_in(pin_in), .rdcap(rdcap),
    .capval(o_val[1]), .caplvl(o_lvl[1]),
    .capvld(o_vld[1]), .capcnt(o_cnt[1]),
    .ovf(o_ovf[1])
  );

  // behavioural model: level history, tick, queue of entries
  logic [7:0]  m_cfg  [2];
  logic        m_old  [2];
  logic        m_new  [2];
  logic [31:0] m_tick [2];
  logic [31:0] m_last [2];
  bit          m_arm  [2];
  bit          m_ovf  [2];
  logic [32:0] m_q    [2][$];

  function automatic logic [31:0] base(input int i);
    return (i == 0) ? 32'h0 : WBASE;
  endfunction

  always @(posedge clk or negedge ena) begin
    for (int i = 0; i < 2; i++) begin
      if (!ena) begin
        m_cfg[i] = 8'h0;
        m_old[i] = 1'b0;
        m_new[i] = 1'b0;
        m_tick[i] = base(i);
        m_last[i] = 32'h0;
        m_arm[i] = 1'b0;
        m_ovf[i] = 1'b0;
        m_q[i].delete();
      end else begin
        bit rise, fall, edge_hit, has;
        logic [32:0] ent;
        rise = !m_old[i] && m_new[i] && m_cfg[i][5];
        fall = m_old[i] && !m_new[i] && m_cfg[i][6];
        edge_hit = (rise || fall) && !setcap;
        has = 1'b0;
        ent = 33'h0;
        m_old[i] = m_new[i];
        m_new[i] = pin_in[m_cfg[i][4:0]];
        if (setcap) begin
          m_cfg[i] = data[7:0];
          m_tick[i] = base(i);
          m_arm[i] = 1'b0;
          m_ovf[i] = 1'b0;
          m_q[i].delete();
        end else begin
          if (edge_hit) begin
            if (m_cfg[i][7] && !m_arm[i]) begin
              m_arm[i] = 1'b1;
            end else begin
              has = 1'b1;
              ent[32] = rise;
              ent[31:0] = m_cfg[i][7] ?
                m_tick[i] - m_last[i] : m_tick[i];
            end
            m_last[i] = m_tick[i];
          end
          if (rdcap && m_q[i].size() > 0)
            void'(m_q[i].pop_front());
          if (has) begin
            if (m_q[i].size() == DEPTH) m_ovf[i] = 1'b1;
            else m_q[i].push_back(ent);
          end
          m_tick[i] = m_tick[i] + 32'd1;
        end
      end
    end
  end

  // per-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] ev;
        logic el, ed;
        logic [4:0] ec;
        ed = m_q[i].size() > 0;
        ev = ed ? m_q[i][0][31:0] : 32'h0;
        el = ed ? m_q[i][0][32] : 1'b0;
        ec = 5'(m_q[i].size());
        n_checks++;
        if (o_val[i] !== ev || o_lvl[i] !== el ||
            o_vld[i] !== ed || o_cnt[i] !== ec ||
            o_ovf[i] !== m_ovf[i]) begin
          n_err++;
          $display("FAIL cycle_cmp[%0d] t=%0t got val=%h lvl=%b vld=%b cnt=%0d ovf=%b exp val=%h lvl=%b vld=%b cnt=%0d ovf=%b",
                   i, $time, o_val[i], o_lvl[i], o_vld[i],
                   o_cnt[i], o_ovf[i], ev, el, ed, ec, m_ovf[i]);
        end
      end
    end
  end

  task automatic lit(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setc(input logic [7:0] v);
    setcap = 1'b1;
    data = {24'hA5A5A5, v};
    cyc();
    setcap = 1'b0;
    data = 32'h0;
  endtask

  // pin 3 pulses: high 2, low 2; optional pop on step pop_s
  task automatic pulses(input int n, input int pop_s);
    for (int s = 1; s <= n; s++) begin
      pin_in[3] = ((s - 1) % 4) < 2;
      rdcap = (s == pop_s);
      cyc();
    end
    pin_in[3] = 1'b0;
    rdcap = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    cyc();
    chk_en = 1'b1;
    cyc();
    lit("rst_capvld", 32'(o_vld[0]), 32'h0);
    lit("rst_capcnt", 32'(o_cnt[0]), 32'h0);
    lit("rst_capval", o_val[0], 32'h0);
    lit("rst_ovf", 32'(o_ovf[0]), 32'h0);
    ena = 1'b1;
    cyc();

    // timestamp rising on pin 3
    setc(8'h23);
    repeat (9) cyc();
    pin_in[3] = 1'b1;
    cyc();
    lit("ts_latency_vld", 32'(o_vld[0]), 32'h0);
    cyc();
    lit("ts_capvld", 32'(o_vld[0]), 32'h1);
    lit("ts_capval", o_val[0], 32'd10);
    lit("ts_capval_w", o_val[1], 32'hFFFF_FFFA);
    lit("ts_caplvl", 32'(o_lvl[0]), 32'h1);
    lit("ts_capcnt", 32'(o_cnt[0]), 32'h1);
    rdcap = 1'b1;
    cyc();
    rdcap = 1'b0;
    lit("ts_pop_vld", 32'(o_vld[0]), 32'h0);
    pin_in[3] = 1'b0;
    repeat (3) cyc();

    // delta both edges on pin 0, period 7
    setc(8'hE0);
    for (int k = 0; k < 4; k++) begin
      pin_in[0] = ~pin_in[0];
      repeat (7) cyc();
    end
    lit("dl_capcnt", 32'(o_cnt[0]), 32'h3);
    lit("dl_capval", o_val[0], 32'd7);
    lit("dl_capval_w", o_val[1], 32'd7);
    lit("dl_caplvl0", 32'(o_lvl[0]), 32'h0);
    rdcap = 1'b1;
    cyc();
    rdcap = 1'b0;
    lit("dl_caplvl1", 32'(o_lvl[0]), 32'h1);
    lit("dl_capval2", o_val[0], 32'd7);
    rdcap = 1'b1;
    repeat (3) cyc();
    rdcap = 1'b0;

    // overflow: 5 edges, no pops
    setc(8'h23);
    pulses(20, 0);
    lit("ov_capcnt", 32'(o_cnt[0]), 32'h4);
    lit("ov_ovf", 32'(o_ovf[0]), 32'h1);
    lit("ov_head", o_val[0], 32'd1);
    lit("ov_head_w", o_val[1], 32'hFFFF_FFF1);
    setc(8'h23);
    lit("ov_clr_cnt", 32'(o_cnt[0]), 32'h0);
    lit("ov_clr_ovf", 32'(o_ovf[0]), 32'h0);

    // full with simultaneous push and pop
    pulses(20, 18);
    lit("fp_capcnt", 32'(o_cnt[0]), 32'h4);
    lit("fp_ovf", 32'(o_ovf[0]), 32'h0);
    lit("fp_head", o_val[0], 32'd5);
    rdcap = 1'b1;
    repeat (3) cyc();
    rdcap = 1'b0;
    lit("fp_tail", o_val[0], 32'd17);
    lit("fp_tail_w", o_val[1], 32'h0000_0001);
    rdcap = 1'b1;
    cyc();
    rdcap = 1'b0;

    // delta rising across tick wraparound
    setc(8'hA3);
    pulses(20, 0);
    lit("wr_capcnt", 32'(o_cnt[1]), 32'h4);
    lit("wr_head_w", o_val[1], 32'd4);
    rdcap = 1'b1;
    repeat (3) cyc();
    rdcap = 1'b0;
    lit("wr_last_w", o_val[1], 32'd4);
    rdcap = 1'b1;
    cyc();
    rdcap = 1'b0;

    // mode off, then push with pop on empty
    setc(8'h03);
    pulses(8, 0);
    lit("off_capcnt", 32'(o_cnt[0]), 32'h0);
    setc(8'h23);
    pulses(4, 2);
    lit("em_capcnt", 32'(o_cnt[0]), 32'h1);
    lit("em_capval", o_val[0], 32'd1);

    // setcap on the edge's push cycle discards it
    setc(8'h23);
    pin_in[3] = 1'b1;
    cyc();
    setc(8'h23);
    pin_in[3] = 1'b0;
    repeat (2) cyc();
    lit("sc_prio_cnt", 32'(o_cnt[0]), 32'h0);

    // async reset mid-stream with 3 entries
    setc(8'h23);
    pulses(12, 0);
    lit("ar_pre_cnt", 32'(o_cnt[0]), 32'h3);
    #2 ena = 1'b0;
    #1;
    lit("ar_capcnt", 32'(o_cnt[0]), 32'h0);
    lit("ar_capvld", 32'(o_vld[0]), 32'h0);
    lit("ar_capval", o_val[0], 32'h0);
    lit("ar_caplvl", 32'(o_lvl[0]), 32'h0);
    lit("ar_ovf", 32'(o_ovf[1]), 32'h0);
    @(negedge clk);
    cyc();
    ena = 1'b1;
    pulses(8, 0);
    lit("ar_idle_cnt", 32'(o_cnt[0]), 32'h0);
    setc(8'hA3);
    pulses(8, 0);
    lit("ar_delta_cnt", 32'(o_cnt[0]), 32'h1);
    lit("ar_delta_val", o_val[0], 32'd4);
    repeat (2) cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
